// File: rtl/frame_parse_pkg.sv
// Shared types and constants for the frame parser.
// The CHK state is only present when FRAME_CHK_EN is defined.
package frame_parse_pkg;

  localparam int WORD_W    = 16;
  localparam int ERR_CNT_W = 8;

  localparam logic [WORD_W-1:0] DEF_SYNC_WORD = 16'hF731;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    LEN,
    PAY
`ifdef FRAME_CHK_EN
    , CHK
`endif
  } state_t;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/frame_chk_acc.sv
// Purpose: 16-bit modular running sum of frame words (length + payload).
// Latency: sum reflects an added word on the cycle after add_en.
// Backpressure: none; clr takes priority over add_en.
module frame_chk_acc
  import frame_parse_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              clr,
  input  logic              add_en,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] sum
);

  // Accumulate words; reset and clear both restart the sum at zero.
  always_ff @(posedge CLK) begin
    if (!RSTX || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/frame_parse.sv
// Purpose: find SYNC_WORD, read length, forward payload, flag length/abort (and checksum with FRAME_CHK_EN).
// Latency: each payload word appears on DOUT exactly one cycle after its DIPUSH; EOF/FRM_ERR are registered.
// Backpressure: none; a word may arrive every cycle and gaps of any length are tolerated.
module frame_parse
  import frame_parse_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int unsigned       MAX_LEN   = 256
) (
  input  logic                 CLK,
  input  logic                 RSTX,
  input  logic                 PHY_INIT,
  input  logic                 ALIGNED,
  input  logic                 DIPUSH,
  input  logic [WORD_W-1:0]    DIN,
  output logic                 DOPUSH,
  output logic [WORD_W-1:0]    DOUT,
  output logic                 SOF,
  output logic                 EOF,
  output logic                 FRM_ERR,
  output logic [15:0]          FRM_CNT,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [WORD_W-1:0] MAX_LEN_W = WORD_W'(MAX_LEN);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] len_q, len_nxt;
  logic [WORD_W-1:0] rem_q, rem_nxt;
  logic              dopush_nxt, sof_nxt, eof_nxt, err_nxt;
  logic [WORD_W-1:0] dout_nxt;
  logic              frm_inc, err_inc;
  logic              clr;

  // PHY_INIT behaves like reset, so both share one synchronous clear.
  assign clr = !RSTX || PHY_INIT;

`ifdef FRAME_CHK_EN
  logic              acc_clr, acc_add;
  logic [WORD_W-1:0] acc_sum;

  frame_chk_acc u_chk_acc (
    .CLK    (CLK),
    .RSTX   (RSTX),
    .clr    (acc_clr | PHY_INIT),
    .add_en (acc_add),
    .data   (DIN),
    .sum    (acc_sum)
  );
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output decode; loss of alignment overrides everything.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len_q;
    rem_nxt    = rem_q;
    dopush_nxt = 1'b0;
    dout_nxt   = DOUT;
    sof_nxt    = 1'b0;
    eof_nxt    = 1'b0;
    err_nxt    = 1'b0;
    frm_inc    = 1'b0;
    err_inc    = 1'b0;
`ifdef FRAME_CHK_EN
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
`endif
    if (!ALIGNED) begin
      state_nxt = IDLE;
      // Losing lock mid-frame is an abort; in IDLE/HUNT there is no frame to lose.
      if (state != IDLE && state != HUNT) begin
        err_nxt = 1'b1;
        err_inc = 1'b1;
      end
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (DIPUSH && DIN == SYNC_WORD) begin
            state_nxt = LEN;
`ifdef FRAME_CHK_EN
            acc_clr   = 1'b1;
`endif
          end
        end
        LEN: begin
          if (DIPUSH) begin
            if (DIN > MAX_LEN_W) begin
              err_nxt   = 1'b1;
              err_inc   = 1'b1;
              state_nxt = HUNT;
            end else if (DIN == '0) begin
`ifdef FRAME_CHK_EN
              acc_add   = 1'b1;
              state_nxt = CHK;
`else
              eof_nxt   = 1'b1;
              frm_inc   = 1'b1;
              state_nxt = HUNT;
`endif
            end else begin
              len_nxt   = DIN;
              rem_nxt   = DIN;
              state_nxt = PAY;
`ifdef FRAME_CHK_EN
              acc_add   = 1'b1;
`endif
            end
          end
        end
        PAY: begin
          if (DIPUSH) begin
            dopush_nxt = 1'b1;
            dout_nxt   = DIN;
            // Nothing consumed yet means this is payload word 1.
            sof_nxt    = (rem_q == len_q);
            rem_nxt    = rem_q - 1'b1;
`ifdef FRAME_CHK_EN
            acc_add    = 1'b1;
            if (rem_q == 16'd1) state_nxt = CHK;
`else
            if (rem_q == 16'd1) begin
              eof_nxt   = 1'b1;
              frm_inc   = 1'b1;
              state_nxt = HUNT;
            end
`endif
          end
        end
`ifdef FRAME_CHK_EN
        CHK: begin
          if (DIPUSH) begin
            eof_nxt   = 1'b1;
            state_nxt = HUNT;
            if (DIN != acc_sum) begin
              err_nxt = 1'b1;
              err_inc = 1'b1;
            end else begin
              frm_inc = 1'b1;
            end
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered outputs, length/remaining counters and statistics.
  always_ff @(posedge CLK) begin
    if (clr) begin
      DOPUSH  <= 1'b0;
      DOUT    <= '0;
      SOF     <= 1'b0;
      EOF     <= 1'b0;
      FRM_ERR <= 1'b0;
      FRM_CNT <= '0;
      ERR_CNT <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      DOPUSH  <= dopush_nxt;
      DOUT    <= dout_nxt;
      SOF     <= sof_nxt;
      EOF     <= eof_nxt;
      FRM_ERR <= err_nxt;
      FRM_CNT <= FRM_CNT + 16'(frm_inc);
      ERR_CNT <= err_inc ? err_cnt_inc(ERR_CNT) : ERR_CNT;
      len_q   <= len_nxt;
      rem_q   <= rem_nxt;
    end
  end

endmodule

// File: doc/frame_parse.md
FRAME_PARSE -- requirements
Module: frame_parse

Interface
REQ-001 Parameters SHALL be: SYNC_WORD, 16'hF731, frame header word; MAX_LEN, 256, largest legal payload length in words (1..65535).
REQ-002 CLK  in  1  single clock; all logic on its rising edge.
REQ-003 RSTX  in  1  reset, synchronous, active-low.
REQ-004 PHY_INIT  in  1  link re-init; synchronous clear, equivalent to reset except parameters.
REQ-005 ALIGNED  in  1  word aligner lock indication.
REQ-006 DIPUSH  in  1  DIN valid this cycle; no backpressure.
REQ-007 DIN  in  16  aligned input word.
REQ-008 DOPUSH  out  1  payload word valid on DOUT.
REQ-009 DOUT  out  16  payload word, registered.
REQ-010 SOF  out  1  first payload word; coincident with DOPUSH.
REQ-011 EOF  out  1  one-cycle frame-end pulse.
REQ-012 FRM_ERR  out  1  one-cycle error pulse (checksum, length or abort).
REQ-013 FRM_CNT  out  16  good-frame count, wraps at 65535->0.
REQ-014 ERR_CNT  out  8  error count, saturates at 255.

Function
REQ-015 States SHALL be IDLE, HUNT, LEN, PAY, CHK; CHK exists only with FRAME_CHK_EN.
REQ-016 IDLE->HUNT when ALIGNED=1; any state->IDLE when ALIGNED=0.
REQ-017 HUNT: on DIPUSH with DIN==SYNC_WORD ->LEN; other words discarded.
REQ-018 LEN: on DIPUSH capture DIN as length L; L>MAX_LEN -> FRM_ERR pulse, ERR_CNT+1, ->HUNT; L==0 -> CHK (checked build) or EOF pulse, FRM_CNT+1, ->HUNT (unchecked build); else ->PAY.
REQ-019 PAY: each DIPUSH SHALL produce DOPUSH=1, DOUT=DIN exactly one cycle later; remaining-word counter decrements; after the L-th word ->CHK (checked) or ->HUNT (unchecked).
REQ-020 SOF SHALL accompany the DOPUSH of payload word 1 only; L==0 frames produce no SOF.
REQ-021 Unchecked build: EOF SHALL coincide with DOPUSH of payload word L; FRM_CNT increments the same cycle.
REQ-022 Checksum SHALL be the 16-bit modular sum of the length word and all payload words, sync word excluded.
REQ-023 CHK: on DIPUSH compare DIN with checksum; one cycle later EOF=1, DOPUSH=0, FRM_ERR=1 on mismatch; match -> FRM_CNT+1, mismatch -> ERR_CNT+1; ->HUNT.
REQ-024 Cycles without DIPUSH SHALL hold state and counters; gaps of any length are legal mid-frame.
REQ-025 ALIGNED falling while in LEN, PAY or CHK SHALL abort: FRM_ERR pulse next cycle, no EOF, ERR_CNT+1; a DIPUSH in that cycle is ignored.
REQ-026 A SYNC_WORD value inside LEN/PAY/CHK SHALL be treated as data, not resync.
REQ-027 Words arriving back-to-back SHALL be accepted every cycle; the sync word of the next frame may immediately follow the last word of the previous frame.

Reset
REQ-028 RSTX=0 or PHY_INIT=1 at a clock edge SHALL set state IDLE and DOPUSH, DOUT, SOF, EOF, FRM_ERR, FRM_CNT, ERR_CNT, length, checksum to 0; PHY_INIT mid-frame produces no FRM_ERR pulse.

Configuration
REQ-029 Macro FRAME_CHK_EN defined: trailer checksum word required and checked (REQ-022/023). Undefined: no trailer, CHK state and checksum logic absent, FRM_ERR only from length/abort.

Structure
REQ-030 Package frame_parse_pkg SHALL hold the state enum typedef, default SYNC_WORD, word width 16 and ERR_CNT width 8.
REQ-031 Checksum accumulator SHALL be sub-module frame_chk_acc (clear, add-enable, 16-bit data, 16-bit sum), instantiated only under FRAME_CHK_EN.

Verification
REQ-032 Checked build, ALIGNED=1, words F731,0003,1111,2222,3333,6669 -> three DOPUSH 1111/2222/3333, SOF on first, EOF with FRM_ERR=0 after 6669, FRM_CNT=1.
REQ-033 Same frame with trailer 6668 -> identical payload output, EOF with FRM_ERR=1, ERR_CNT=1, FRM_CNT=0.
REQ-034 Length word 0101 with MAX_LEN=256 -> FRM_ERR next cycle, no DOPUSH, back to HUNT; following valid frame parsed normally.
REQ-035 ALIGNED dropped after payload word 2 of L=5 -> FRM_ERR pulse, no EOF, state IDLE, ERR_CNT=1.
REQ-036 Unchecked build, F731,0000 then F731,0001,ABCD back-to-back -> EOF alone for frame 1; DOPUSH ABCD with SOF and EOF together; FRM_CNT=2.
REQ-037 300 error frames -> ERR_CNT holds 255; PHY_INIT pulse -> all counters 0, state IDLE.
